// File: rtl/dp_ram_param.sv
// Simple dual-port RAM (one write port, one registered read port) with a hardware clear sweep.
// Optional even-parity protection per word when DP_RAM_PARITY_EN is defined (adds par_err).
module dp_ram_param #(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 10,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy
`ifdef DP_RAM_PARITY_EN
  ,
  output logic              par_err
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;
`ifdef DP_RAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [MEM_W-1:0]  mem_wdata;
  logic [MEM_W-1:0]  mem_rword;
  logic [MEM_W-1:0]  mem [DEPTH];
`ifdef DP_RAM_PARITY_EN
  logic              par_err_q, par_err_d;
`endif

  // Stored word layout: parity bit (when enabled) above the data bits.
  function automatic logic [MEM_W-1:0] encode(input logic [DATA_W-1:0] d);
`ifdef DP_RAM_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  assign mem_rword = mem[rd_addr];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = wr_addr;
    mem_wdata  = encode(wr_data);
`ifdef DP_RAM_PARITY_EN
    par_err_d  = par_err_q;
`endif
    case (state_q)
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = encode(CLEAR_VAL);
        if (clr) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (&cnt_q) state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (clr) begin
          // Clear wins: the same-cycle write and read are dropped.
          state_d = S_CLEAR;
          cnt_d   = '0;
        end else begin
          mem_we = wr_en;
          if (rd_en) begin
            rd_valid_d = 1'b1;
            if (wr_en && (wr_addr == rd_addr)) begin
              rd_data_d = wr_data;
`ifdef DP_RAM_PARITY_EN
              par_err_d = 1'b0;
`endif
            end else begin
              rd_data_d = mem_rword[DATA_W-1:0];
`ifdef DP_RAM_PARITY_EN
              par_err_d = (^mem_rword[DATA_W-1:0]) != mem_rword[DATA_W];
`endif
            end
          end
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_CLEAR;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
`ifdef DP_RAM_PARITY_EN
      par_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
`ifdef DP_RAM_PARITY_EN
      par_err_q  <= par_err_d;
`endif
    end
  end

  // Array kept out of the reset domain so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign busy     = (state_q == S_CLEAR);
`ifdef DP_RAM_PARITY_EN
  assign par_err  = par_err_q;
`endif

endmodule

// File: tb/tb_dp_ram_param.sv
// Self-checking bench for dp_ram_param: directed steps plus random traffic against an array model.
// Exercises the parity path too when DP_RAM_PARITY_EN is defined.
module tb_dp_ram_param;

  localparam int             DW    = 16;
  localparam int             AW    = 4;
  localparam int             DEPTH = 16;
  localparam logic [DW-1:0]  CV    = 16'h0000;

  logic          clk;
  logic          reset;
  logic          clr;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          busy;
`ifdef DP_RAM_PARITY_EN
  logic          par_err;
`endif

  dp_ram_param #(.DATA_W(DW), .ADDR_W(AW), .CLEAR_VAL(CV)) dut (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .busy     (busy)
`ifdef DP_RAM_PARITY_EN
    ,
    .par_err  (par_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] ref_mem [DEPTH];
  bit            ref_bad [DEPTH];
  int            clear_left;
  logic [DW-1:0] exp_rd;
  logic          exp_valid;
  logic          exp_perr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_fill();
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = CV;
      ref_bad[i] = 1'b0;
    end
  endtask

  task automatic model_reset();
    clear_left = DEPTH;
    exp_rd     = '0;
    exp_valid  = 1'b0;
    exp_perr   = 1'b0;
    model_fill();
  endtask

  // Expected effect of one clock edge given the inputs currently applied.
  task automatic model_edge();
    if (clear_left > 0) begin
      exp_valid = 1'b0;
      if (clr) clear_left = DEPTH;
      else     clear_left--;
    end else if (clr) begin
      clear_left = DEPTH;
      exp_valid  = 1'b0;
      model_fill();
    end else begin
      if (rd_en) begin
        exp_valid = 1'b1;
        if (wr_en && wr_addr == rd_addr) begin
          exp_rd   = wr_data;
          exp_perr = 1'b0;
        end else begin
          exp_rd   = ref_mem[rd_addr];
          exp_perr = ref_bad[rd_addr];
        end
      end else begin
        exp_valid = 1'b0;
      end
      if (wr_en) begin
        ref_mem[wr_addr] = wr_data;
        ref_bad[wr_addr] = 1'b0;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".busy"},     32'(busy),     32'(clear_left > 0));
    check({tag, ".rd_valid"}, 32'(rd_valid), 32'(exp_valid));
    check({tag, ".rd_data"},  32'(rd_data),  32'(exp_rd));
`ifdef DP_RAM_PARITY_EN
    check({tag, ".par_err"},  32'(par_err),  32'(exp_perr));
`endif
  endtask

  task automatic drive(input logic c, input logic we, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra);
    clr = c; wr_en = we; wr_addr = wa; wr_data = wd; rd_en = re; rd_addr = ra;
  endtask

  task automatic cycle(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_outputs(tag);
    $display("[TB] %s busy=%0b rd_valid=%0b rd_data=%04h", tag, busy, rd_valid, rd_data);
  endtask

  task automatic idle_cycle(input string tag);
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
    cycle(tag);
  endtask

  // Asynchronous reset pulse: checked right away, held two edges, released mid-cycle.
  task automatic do_reset(input string tag);
    reset = 1'b0;
    model_reset();
    #1;
    check_outputs({tag, ".async"});
    repeat (2) @(posedge clk);
    #1;
    check_outputs({tag, ".held"});
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
    #2;
    do_reset("por");

    // Sweep after reset: random port activity must be ignored.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'($urandom), 4'($urandom), 16'($urandom), 1'($urandom), 4'($urandom));
      cycle("sweep0");
    end
    idle_cycle("after_sweep0");

    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b1, 4'(a));
      cycle("read_all");
    end
    idle_cycle("read_all_end");

    drive(1'b0, 1'b1, 4'd3, 16'hBEEF, 1'b0, '0); cycle("wr_beef");
    drive(1'b0, 1'b0, '0, '0, 1'b1, 4'd3);       cycle("rd_beef");
    idle_cycle("hold_beef");

    drive(1'b0, 1'b1, 4'd5, 16'hAAAA, 1'b0, '0);   cycle("wr_aaaa");
    drive(1'b0, 1'b1, 4'd6, 16'h7777, 1'b1, 4'd5); cycle("rdw_diff");
    drive(1'b0, 1'b1, 4'd5, 16'h1234, 1'b1, 4'd5); cycle("rdw_same");
    drive(1'b0, 1'b0, '0, '0, 1'b1, 4'd5);         cycle("rd_after");

    drive(1'b1, 1'b1, 4'd2, 16'h5555, 1'b1, 4'd2); cycle("clr_wr");
    for (int i = 0; i < DEPTH - 1; i++) idle_cycle("clr_sweep");
    idle_cycle("clr_done");
    drive(1'b0, 1'b0, '0, '0, 1'b1, 4'd2); cycle("rd_cleared");

    drive(1'b1, 1'b0, '0, '0, 1'b0, '0); cycle("clr2");
    for (int i = 0; i < 6; i++) idle_cycle("clr2_sweep");
    do_reset("mid_sweep");
    for (int i = 0; i < DEPTH; i++) idle_cycle("resweep");
    idle_cycle("resweep_done");

`ifdef DP_RAM_PARITY_EN
    drive(1'b0, 1'b1, 4'd1, 16'h0001, 1'b0, '0); cycle("par_wr");
    drive(1'b0, 1'b0, '0, '0, 1'b1, 4'd1);       cycle("par_rd_ok");
    dut.mem[1][0] = ~dut.mem[1][0];
    ref_mem[1]    = ref_mem[1] ^ 16'h0001;
    ref_bad[1]    = 1'b1;
    drive(1'b0, 1'b0, '0, '0, 1'b1, 4'd1);       cycle("par_rd_bad");
    idle_cycle("par_hold");
`endif

    for (int i = 0; i < 400; i++) begin
      logic [AW-1:0] wa;
      logic [AW-1:0] ra;
      wa = 4'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom);
      drive(($urandom_range(0, 63) == 0), 1'($urandom), wa, 16'($urandom), 1'($urandom), ra);
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
